// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with shared prescaler, double-buffered
// duty/period and per-channel output polarity.
module pwm_multi #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned PRE_W  = 8,
    parameter int unsigned CH_W   = 2
) (
    input  logic              SYSCLK,
    input  logic              NSYSRESET,
    input  logic              enable,
    input  logic [PRE_W-1:0]  prescale,
    input  logic [CNT_W-1:0]  period,
    input  logic [NUM_CH-1:0] pol,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_duty,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    logic [PRE_W-1:0]  pre_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_act;
    logic [CNT_W-1:0]  shadow [NUM_CH];
    logic [CNT_W-1:0]  active [NUM_CH];

    logic              tick_c;
    logic              run_c;
    logic              wrap_c;
    logic [NUM_CH-1:0] wr_sel_c;
    logic [NUM_CH-1:0] raw_c;

    // Tick, boundary detect, write decode and raw compare
    always_comb begin
        tick_c   = (pre_cnt == prescale);
        run_c    = (period_act != '0);
        wrap_c   = tick_c && run_c && (cnt == period_act - CNT_W'(1));
        wr_sel_c = '0;
        raw_c    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_sel_c[i] = wr_en && (32'(wr_ch) == i);
            raw_c[i]    = run_c && (cnt < active[i]);
        end
    end

    // Prescaler: wraps on tick, naturally wraps at all-ones if prescale drops
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            pre_cnt <= '0;
        end else if (!enable || tick_c) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Main counter, active period and boundary pulse
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            cnt          <= '0;
            period_act   <= '0;
            period_start <= 1'b0;
        end else if (!enable) begin
            cnt          <= '0;
            period_act   <= period;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap_c;
            if (tick_c) begin
                if (!run_c || wrap_c) begin
                    cnt        <= '0;
                    period_act <= period;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Shadow duty registers; out-of-range channels decode to no write
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_sel_c[i]) shadow[i] <= wr_duty;
            end
        end
    end

    // Active duty: follows shadow while idle, else updates only at the boundary
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            for (int unsigned i = 0; i < NUM_CH; i++) active[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!enable) begin
                    active[i] <= shadow[i];
                end else if (wrap_c) begin
                    active[i] <= wr_sel_c[i] ? wr_duty : shadow[i];
                end
            end
        end
    end

    // Registered outputs with polarity applied
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            pwm_out <= '0;
        end else if (!enable) begin
            pwm_out <= pol;
        end else begin
            pwm_out <= raw_c ^ pol;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: per-period high-time and pulse-spacing
// expectations computed arithmetically from the programmed configuration.
module tb_pwm_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PRE_W  = 8;
    localparam int unsigned CH_W   = 3;

    logic              SYSCLK    = 1'b0;
    logic              NSYSRESET = 1'b0;
    logic              enable    = 1'b0;
    logic [PRE_W-1:0]  prescale  = '0;
    logic [CNT_W-1:0]  period    = '0;
    logic [NUM_CH-1:0] pol       = '0;
    logic              wr_en     = 1'b0;
    logic [CH_W-1:0]   wr_ch     = '0;
    logic [CNT_W-1:0]  wr_duty   = '0;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;

    int errors = 0;
    int checks = 0;

    int          hi_cnt [NUM_CH];
    int          pulse_at;
    logic [63:0] trace0;
    int          r_duty [NUM_CH];

    pwm_multi #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .PRE_W (PRE_W),
        .CH_W  (CH_W)
    ) dut (
        .SYSCLK      (SYSCLK),
        .NSYSRESET   (NSYSRESET),
        .enable      (enable),
        .prescale    (prescale),
        .period      (period),
        .pol         (pol),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    always #5 SYSCLK = ~SYSCLK;

    // SYSCLK cycles per period that a channel's pin is high
    function automatic int exp_high(input int d, input int p, input int ps, input logic pl);
        int act;
        act = ((d < p) ? d : p) * (ps + 1);
        return pl ? (p * (ps + 1) - act) : act;
    endfunction

    task automatic step();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic wr(input int ch, input int d);
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_duty = CNT_W'(d);
        step();
        wr_en   = 1'b0;
    endtask

    // Observe len cycles: per-channel high count, first pulse index, ch0 trace
    task automatic measure(input int len, input int wr_at, input int wch, input int wd,
                           input int chg_at, input int new_per);
        for (int i = 0; i < NUM_CH; i++) hi_cnt[i] = 0;
        pulse_at = 0;
        trace0   = '0;
        for (int j = 1; j <= len; j++) begin
            if (j == wr_at) begin
                wr_en   = 1'b1;
                wr_ch   = CH_W'(wch);
                wr_duty = CNT_W'(wd);
            end
            if (j == chg_at) period = CNT_W'(new_per);
            step();
            wr_en = 1'b0;
            for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) hi_cnt[i]++;
            if (pwm_out[0] && j <= 64) trace0[j-1] = 1'b1;
            if (period_start && pulse_at == 0) pulse_at = j;
        end
    endtask

    task automatic test_reset();
        NSYSRESET = 1'b0;
        enable    = 1'b0;
        pol       = 4'b0010;
        repeat (10) step();
        checks++;
        if (pwm_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pwm: got %b expected 0000", pwm_out);
        end
        checks++;
        if (period_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ps: got %b expected 0", period_start);
        end
        NSYSRESET = 1'b1;
        step();
        step();
        checks++;
        if (pwm_out !== 4'b0010) begin
            errors++;
            $display("FAIL idle_pwm: got %b expected 0010", pwm_out);
        end
        checks++;
        if (period_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_ps: got %b expected 0", period_start);
        end
    endtask

    task automatic test_basic();
        pol      = 4'b0000;
        prescale = '0;
        period   = 16'd10;
        wr(0, 3);
        step();
        r_duty = '{3, 0, 0, 0};
        enable = 1'b1;
        for (int m = 0; m < 2; m++) begin
            measure(10, 0, 0, 0, 0, 0);
            checks++;
            if (pulse_at !== 10) begin
                errors++;
                $display("FAIL basic_pulse%0d: got %0d expected 10", m, pulse_at);
            end
            checks++;
            if (trace0 !== 64'h7) begin
                errors++;
                $display("FAIL basic_trace%0d: got %h expected 7", m, trace0);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                checks++;
                if (hi_cnt[i] !== exp_high(r_duty[i], 10, 0, pol[i])) begin
                    errors++;
                    $display("FAIL basic_high ch%0d: got %0d expected %0d", i, hi_cnt[i],
                             exp_high(r_duty[i], 10, 0, pol[i]));
                end
            end
        end
    endtask

    task automatic test_double_buffer();
        int exp0 [3];
        exp0 = '{3, 7, 2};
        for (int m = 0; m < 3; m++) begin
            if (m == 0) measure(10, 6, 0, 7, 0, 0);
            else if (m == 1) measure(10, 10, 0, 2, 0, 0);
            else measure(10, 0, 0, 0, 0, 0);
            checks++;
            if (pulse_at !== 10) begin
                errors++;
                $display("FAIL dbuf_pulse%0d: got %0d expected 10", m, pulse_at);
            end
            checks++;
            if (hi_cnt[0] !== exp0[m]) begin
                errors++;
                $display("FAIL dbuf_high%0d: got %0d expected %0d", m, hi_cnt[0], exp0[m]);
            end
        end
    endtask

    task automatic test_extremes();
        enable = 1'b0;
        pol    = 4'b0010;
        wr(0, 0);
        wr(1, 3);
        wr(2, 10);
        wr(3, 65535);
        step();
        r_duty = '{0, 3, 10, 65535};
        checks++;
        if (pwm_out !== 4'b0010) begin
            errors++;
            $display("FAIL ext_idle: got %b expected 0010", pwm_out);
        end
        enable = 1'b1;
        for (int m = 0; m < 2; m++) begin
            measure(10, 0, 0, 0, 0, 0);
            checks++;
            if (pulse_at !== 10) begin
                errors++;
                $display("FAIL ext_pulse%0d: got %0d expected 10", m, pulse_at);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                checks++;
                if (hi_cnt[i] !== exp_high(r_duty[i], 10, 0, pol[i])) begin
                    errors++;
                    $display("FAIL ext_high ch%0d: got %0d expected %0d", i, hi_cnt[i],
                             exp_high(r_duty[i], 10, 0, pol[i]));
                end
            end
        end
        step();
        checks++;
        if (pwm_out[3:2] !== 2'b11) begin
            errors++;
            $display("FAIL ext_full_after_wrap: got %b expected 11", pwm_out[3:2]);
        end
    endtask

    task automatic test_prescale_period();
        int lens [3];
        int pers [3];
        lens = '{20, 20, 32};
        pers = '{5, 5, 8};
        enable   = 1'b0;
        prescale = 8'd3;
        period   = 16'd5;
        wr(0, 2);
        step();
        r_duty[0] = 2;
        enable = 1'b1;
        for (int m = 0; m < 3; m++) begin
            if (m == 1) measure(lens[m], 0, 0, 0, 5, 8);
            else measure(lens[m], 0, 0, 0, 0, 0);
            checks++;
            if (pulse_at !== lens[m]) begin
                errors++;
                $display("FAIL pre_pulse%0d: got %0d expected %0d", m, pulse_at, lens[m]);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                checks++;
                if (hi_cnt[i] !== exp_high(r_duty[i], pers[m], 3, pol[i])) begin
                    errors++;
                    $display("FAIL pre_high%0d ch%0d: got %0d expected %0d", m, i, hi_cnt[i],
                             exp_high(r_duty[i], pers[m], 3, pol[i]));
                end
            end
        end
    endtask

    task automatic test_disruption();
        // counter sits at 0 for four cycles here; all raw compares are 1
        step();
        checks++;
        if (pwm_out !== 4'b1101) begin
            errors++;
            $display("FAIL pol_before: got %b expected 1101", pwm_out);
        end
        pol = 4'b1101;
        step();
        checks++;
        if (pwm_out !== 4'b0010) begin
            errors++;
            $display("FAIL pol_live: got %b expected 0010", pwm_out);
        end
        pol = 4'b0010;
        step();
        checks++;
        if (pwm_out !== 4'b1101) begin
            errors++;
            $display("FAIL mid_pulse: got %b expected 1101", pwm_out);
        end
        enable = 1'b0;
        step();
        checks++;
        if (pwm_out !== 4'b0010 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop: got %b/%b expected 0010/0", pwm_out, period_start);
        end
        enable = 1'b1;
        repeat (7) step();
        #2;
        NSYSRESET = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 4'b0000 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %b/%b expected 0000/0", pwm_out, period_start);
        end
        enable = 1'b0;
        repeat (3) step();
        NSYSRESET = 1'b1;
        step();
        checks++;
        if (pwm_out !== 4'b0010) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 0010", pwm_out);
        end
        wr(0, 5);
        step();
        r_duty = '{5, 0, 0, 0};
        enable = 1'b1;
        measure(32, 0, 0, 0, 0, 0);
        checks++;
        if (pulse_at !== 32) begin
            errors++;
            $display("FAIL restart_pulse: got %0d expected 32", pulse_at);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            checks++;
            if (hi_cnt[i] !== exp_high(r_duty[i], 8, 3, pol[i])) begin
                errors++;
                $display("FAIL restart_high ch%0d: got %0d expected %0d", i, hi_cnt[i],
                         exp_high(r_duty[i], 8, 3, pol[i]));
            end
        end
    endtask

    task automatic test_bad_channel();
        enable = 1'b0;
        wr(5, 9);
        wr(4, 9);
        wr(7, 9);
        step();
        enable = 1'b1;
        measure(32, 0, 0, 0, 0, 0);
        checks++;
        if (pulse_at !== 32) begin
            errors++;
            $display("FAIL badch_pulse: got %0d expected 32", pulse_at);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            checks++;
            if (hi_cnt[i] !== exp_high(r_duty[i], 8, 3, pol[i])) begin
                errors++;
                $display("FAIL badch_high ch%0d: got %0d expected %0d", i, hi_cnt[i],
                         exp_high(r_duty[i], 8, 3, pol[i]));
            end
        end
    endtask

    task automatic test_zero_period();
        int pulses;
        int off_level;
        enable   = 1'b0;
        period   = '0;
        prescale = '0;
        step();
        step();
        enable    = 1'b1;
        pulses    = 0;
        off_level = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            if (period_start) pulses++;
            if (pwm_out !== pol) off_level++;
        end
        checks++;
        if (pulses !== 0 || off_level !== 0) begin
            errors++;
            $display("FAIL zero_period: got pulses=%0d active=%0d expected 0/0", pulses, off_level);
        end
        period = 16'd4;
        step();
        checks++;
        if (pwm_out !== pol) begin
            errors++;
            $display("FAIL zero_reload: got %b expected %b", pwm_out, pol);
        end
        measure(4, 0, 0, 0, 0, 0);
        checks++;
        if (pulse_at !== 4) begin
            errors++;
            $display("FAIL zero_start_pulse: got %0d expected 4", pulse_at);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            checks++;
            if (hi_cnt[i] !== exp_high(r_duty[i], 4, 0, pol[i])) begin
                errors++;
                $display("FAIL zero_start_high ch%0d: got %0d expected %0d", i, hi_cnt[i],
                         exp_high(r_duty[i], 4, 0, pol[i]));
            end
        end
    endtask

    task automatic test_random();
        int ps, per, len, wat, wch, wd;
        for (int t = 0; t < 8; t++) begin
            enable   = 1'b0;
            ps       = int'($urandom_range(0, 3));
            per      = int'($urandom_range(1, 12));
            prescale = PRE_W'(ps);
            period   = CNT_W'(per);
            pol      = NUM_CH'($urandom_range(0, 15));
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty[i] = int'($urandom_range(0, 14));
                wr(i, r_duty[i]);
            end
            step();
            len    = per * (ps + 1);
            enable = 1'b1;
            wch    = 0;
            wd     = 0;
            for (int m = 0; m < 3; m++) begin
                if (m == 1) begin
                    wat = int'($urandom_range(1, len));
                    wch = int'($urandom_range(0, NUM_CH - 1));
                    wd  = int'($urandom_range(0, 14));
                    measure(len, wat, wch, wd, 0, 0);
                end else begin
                    measure(len, 0, 0, 0, 0, 0);
                end
                checks++;
                if (pulse_at !== len) begin
                    errors++;
                    $display("FAIL rnd%0d_pulse%0d: got %0d expected %0d", t, m, pulse_at, len);
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    checks++;
                    if (hi_cnt[i] !== exp_high(r_duty[i], per, ps, pol[i])) begin
                        errors++;
                        $display("FAIL rnd%0d_high%0d ch%0d: got %0d expected %0d", t, m, i,
                                 hi_cnt[i], exp_high(r_duty[i], per, ps, pol[i]));
                    end
                end
                if (m == 1) r_duty[wch] = wd;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_double_buffer();
        test_extremes();
        test_prescale_period();
        test_disruption();
        test_bad_channel();
        test_zero_period();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
